// File: rtl/time_keeper_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : time_keeper_if
// Description : Adjust-button inputs and BCD time-of-day outputs of time_keeper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface time_keeper_if;
    logic       adj_hrs;
    logic       adj_min;
    logic       adj_sec;
    logic [3:0] sec_u;
    logic [3:0] sec_d;
    logic [3:0] min_u;
    logic [3:0] min_d;
    logic [3:0] hrs_u;
    logic [3:0] hrs_d;
    logic       sec_tick;

    modport master (
        output adj_hrs, adj_min, adj_sec,
        input  sec_u, sec_d, min_u, min_d, hrs_u, hrs_d, sec_tick
    );

    modport slave (
        input  adj_hrs, adj_min, adj_sec,
        output sec_u, sec_d, min_u, min_d, hrs_u, hrs_d, sec_tick
    );
endinterface
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : time_keeper
// Description : 24-hour BCD clock with 1 Hz divider and push-button adjust.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module time_keeper #(
    parameter int CLK_HZ = 31500000,
    parameter int DIV_W  = 25
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    time_keeper_if.slave  tk
);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);

    // Packed {tens, units}; saturating compares keep any stray value in range.
    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [3:0] d;
        logic [3:0] u;
        d = v[7:4];
        u = v[3:0];
        if (u >= 4'd9) begin
            u = 4'd0;
            d = (d >= 4'd5) ? 4'd0 : d + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {d, u};
    endfunction

    function automatic logic [7:0] inc_mod24(input logic [7:0] v);
        logic [3:0] d;
        logic [3:0] u;
        d = v[7:4];
        u = v[3:0];
        if ((d >= 4'd2) && (u >= 4'd3)) begin
            d = 4'd0;
            u = 4'd0;
        end else if (u >= 4'd9) begin
            u = 4'd0;
            d = d + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {d, u};
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_hist;
    logic [7:0]       r_sec;
    logic [7:0]       r_min;
    logic [7:0]       r_hrs;
    logic             r_sec_tick;

    logic [2:0]       w_btn;
    logic [2:0]       w_edge;
    logic             w_edge_hrs;
    logic             w_edge_min;
    logic             w_edge_sec;
    logic             w_any_edge;
    logic             w_tick;
    logic             w_tick_eff;
    logic             w_sec_wrap;
    logic             w_min_wrap;
    logic [7:0]       w_sec_nx;
    logic [7:0]       w_min_nx;
    logic [7:0]       w_hrs_nx;
    logic [DIV_W-1:0] w_div_nx;

    assign w_btn      = {tk.adj_hrs, tk.adj_min, tk.adj_sec};
    assign w_edge     = r_sync2 & ~r_hist;
    assign w_edge_hrs = w_edge[2];
    assign w_edge_min = w_edge[1];
    assign w_edge_sec = w_edge[0];
    assign w_any_edge = |w_edge;

    assign w_tick     = (r_div == C_DIV_LAST);
    // An adjust always wins over a coincident tick; that second is dropped.
    assign w_tick_eff = w_tick & ~w_any_edge;

    assign w_sec_wrap = (r_sec == 8'h59);
    assign w_min_wrap = (r_min == 8'h59);

    always_comb begin
        w_div_nx = r_div + C_DIV_ONE;
        if (w_edge_sec || w_tick) begin
            w_div_nx = '0;
        end
    end

    always_comb begin
        w_sec_nx = r_sec;
        w_min_nx = r_min;
        w_hrs_nx = r_hrs;
        if (w_tick_eff) begin
            w_sec_nx = inc_mod60(r_sec);
            if (w_sec_wrap) begin
                w_min_nx = inc_mod60(r_min);
                if (w_min_wrap) begin
                    w_hrs_nx = inc_mod24(r_hrs);
                end
            end
        end
        if (w_edge_hrs) begin
            w_hrs_nx = inc_mod24(r_hrs);
        end
        if (w_edge_min) begin
            w_min_nx = inc_mod60(r_min);
        end
        if (w_edge_sec) begin
            w_sec_nx = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div      <= '0;
            r_sync1    <= 3'b000;
            r_sync2    <= 3'b000;
            r_hist     <= 3'b000;
            r_sec      <= 8'h00;
            r_min      <= 8'h00;
            r_hrs      <= 8'h00;
            r_sec_tick <= 1'b0;
        end else begin
            r_div      <= w_div_nx;
            r_sync1    <= w_btn;
            r_sync2    <= r_sync1;
            r_hist     <= r_sync2;
            r_sec      <= w_sec_nx;
            r_min      <= w_min_nx;
            r_hrs      <= w_hrs_nx;
            r_sec_tick <= w_tick_eff;
        end
    end

    assign tk.sec_u    = r_sec[3:0];
    assign tk.sec_d    = r_sec[7:4];
    assign tk.min_u    = r_min[3:0];
    assign tk.min_d    = r_min[7:4];
    assign tk.hrs_u    = r_hrs[3:0];
    assign tk.hrs_d    = r_hrs[7:4];
    assign tk.sec_tick = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_time_keeper
// Description : Directed self-checking bench for time_keeper at several CLK_HZ.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_time_keeper;

    logic clk;
    logic rst_a, rst_b, rst_c, rst_d, rst_e;
    int   n_checks;
    int   n_fail;

    time_keeper_if if_a ();
    time_keeper_if if_b ();
    time_keeper_if if_c ();
    time_keeper_if if_d ();
    time_keeper_if if_e ();

    time_keeper #(.CLK_HZ(4),       .DIV_W(25)) u_dut_a (.clk(clk), .reset_n(rst_a), .tk(if_a));
    time_keeper #(.CLK_HZ(2),       .DIV_W(25)) u_dut_b (.clk(clk), .reset_n(rst_b), .tk(if_b));
    time_keeper #(.CLK_HZ(1000000), .DIV_W(25)) u_dut_c (.clk(clk), .reset_n(rst_c), .tk(if_c));
    time_keeper #(.CLK_HZ(64),      .DIV_W(25)) u_dut_d (.clk(clk), .reset_n(rst_d), .tk(if_d));
    time_keeper #(.CLK_HZ(8),       .DIV_W(25)) u_dut_e (.clk(clk), .reset_n(rst_e), .tk(if_e));

    logic [23:0] w_time_a, w_time_b, w_time_c, w_time_d, w_time_e;
    assign w_time_a = {if_a.hrs_d, if_a.hrs_u, if_a.min_d, if_a.min_u, if_a.sec_d, if_a.sec_u};
    assign w_time_b = {if_b.hrs_d, if_b.hrs_u, if_b.min_d, if_b.min_u, if_b.sec_d, if_b.sec_u};
    assign w_time_c = {if_c.hrs_d, if_c.hrs_u, if_c.min_d, if_c.min_u, if_c.sec_d, if_c.sec_u};
    assign w_time_d = {if_d.hrs_d, if_d.hrs_u, if_d.min_d, if_d.min_u, if_d.sec_d, if_d.sec_u};
    assign w_time_e = {if_e.hrs_d, if_e.hrs_u, if_e.min_d, if_e.min_u, if_e.sec_d, if_e.sec_u};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        {rst_a, rst_b, rst_c, rst_d, rst_e} = 5'b00000;
        {if_a.adj_hrs, if_a.adj_min, if_a.adj_sec} = 3'b000;
        {if_b.adj_hrs, if_b.adj_min, if_b.adj_sec} = 3'b000;
        {if_c.adj_hrs, if_c.adj_min, if_c.adj_sec} = 3'b000;
        {if_d.adj_hrs, if_d.adj_min, if_d.adj_sec} = 3'b000;
        {if_e.adj_hrs, if_e.adj_min, if_e.adj_sec} = 3'b000;
        @(negedge clk);

        // Reset state, then first ticks with CLK_HZ=4
        check("a_rst_time", 32'(w_time_a), 32'h0);
        check("a_rst_tick", 32'(if_a.sec_tick), 32'h0);
        rst_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("a_tick", 32'(if_a.sec_tick), 32'((k % 4) == 0));
            if ((k % 4) == 0) check("a_sec_u", 32'(if_a.sec_u), 32'(k / 4));
        end

        // Adjust colliding with tick: edge 40 would tick 09 -> 10
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (37) @(negedge clk);
        check("col_pre", 32'(w_time_a), 32'h000009);
        if_a.adj_min = 1'b1;
        repeat (2) @(negedge clk);
        check("col_wait", 32'(w_time_a), 32'h000009);
        @(negedge clk);
        check("col_time", 32'(w_time_a), 32'h000109);
        check("col_tick", 32'(if_a.sec_tick), 32'h0);
        repeat (4) @(negedge clk);
        check("col_next", 32'(w_time_a), 32'h000110);
        check("col_next_tick", 32'(if_a.sec_tick), 32'h1);
        if_a.adj_min = 1'b0;

        // Reset while adj_hrs held: cleared, then one action as it re-syncs
        if_a.adj_hrs = 1'b1;
        repeat (5) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("rsth_time", 32'(w_time_a), 32'h0);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        check("rsth_pre", 32'({if_a.hrs_d, if_a.hrs_u}), 32'h00);
        @(negedge clk);
        check("rsth_act", 32'({if_a.hrs_d, if_a.hrs_u}), 32'h01);
        repeat (10) @(negedge clk);
        check("rsth_hold", 32'({if_a.hrs_d, if_a.hrs_u}), 32'h01);
        if_a.adj_hrs = 1'b0;

        // Carry chain with CLK_HZ=2: tick k lands on edge 2k
        rst_b = 1'b1;
        repeat (118) @(negedge clk);
        check("b_59s", 32'(w_time_b), 32'h000059);
        repeat (2) @(negedge clk);
        check("b_60s", 32'(w_time_b), 32'h000100);
        repeat (7200 - 120) @(negedge clk);
        check("b_1h", 32'(w_time_b), 32'h010000);

        // Hour adjust wrap
        rst_c = 1'b1;
        for (int h = 1; h <= 24; h++) begin
            if_c.adj_hrs = 1'b1;
            repeat (2) @(negedge clk);
            check("hadj_pre", 32'({if_c.hrs_d, if_c.hrs_u}), 32'(bcd8(h - 1)));
            @(negedge clk);
            check("hadj", 32'({if_c.hrs_d, if_c.hrs_u}), 32'(bcd8(h % 24)));
            repeat (2) @(negedge clk);
            if_c.adj_hrs = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("hadj_ms", 32'(w_time_c[15:0]), 32'h0);

        // Minute adjust, no carry into hours
        rst_c = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        for (int m = 1; m <= 60; m++) begin
            if_c.adj_min = 1'b1;
            repeat (3) @(negedge clk);
            if (m == 59) check("madj_59", 32'(w_time_c), 32'h005900);
            repeat (2) @(negedge clk);
            if_c.adj_min = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("madj_wrap", 32'(w_time_c), 32'h000000);
        if_c.adj_min = 1'b1;
        repeat (100) @(negedge clk);
        if_c.adj_min = 1'b0;
        repeat (5) @(negedge clk);
        check("madj_hold", 32'(w_time_c), 32'h000100);

        // Second clear, CLK_HZ=8: clear edge is edge 43
        rst_e = 1'b1;
        repeat (40) @(negedge clk);
        check("sclr_pre", 32'(w_time_e), 32'h000005);
        if_e.adj_sec = 1'b1;
        repeat (3) @(negedge clk);
        check("sclr_time", 32'(w_time_e), 32'h000000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) if_e.adj_sec = 1'b0;
            check("sclr_tick", 32'(if_e.sec_tick), 32'(k == 8));
        end
        check("sclr_next", 32'(w_time_e), 32'h000001);

        // Midnight rollover: set 23:59 by adjust, clear seconds, then tick through
        rst_d = 1'b1;
        for (int p = 0; p < 59; p++) begin
            if_d.adj_min = 1'b1;
            if (p < 23) if_d.adj_hrs = 1'b1;
            repeat (5) @(negedge clk);
            if_d.adj_min = 1'b0;
            if_d.adj_hrs = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("d_hm", 32'(w_time_d[23:8]), 32'h2359);
        if_d.adj_sec = 1'b1;
        repeat (3) @(negedge clk);
        check("d_clr", 32'(w_time_d), 32'h235900);
        repeat (2) @(negedge clk);
        if_d.adj_sec = 1'b0;
        repeat (59 * 64 - 2) @(negedge clk);
        check("d_235959", 32'(w_time_d), 32'h235959);
        check("d_tick59", 32'(if_d.sec_tick), 32'h1);
        repeat (64) @(negedge clk);
        check("d_midnight", 32'(w_time_d), 32'h000000);
        check("d_tick0", 32'(if_d.sec_tick), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
